instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding memory requests into a small {instr, pc} buffer with decode field slicing.
// Optional opcode legality check when FETCH_ILLEGAL_CHECK_EN is defined.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [6:0]        out_opcode,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_funct3,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [6:0]        out_funct7,
  output logic              out_illegal
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [31:0]       buf_instr [DEPTH];
  logic [ADDR_W-1:0] buf_pc    [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_next;
  logic              push, pop;
  logic              unused_pc_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign target         = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign pc_inc         = pc + ADDR_W'(4);

  assign out_valid = (count != '0);
  assign push      = (state == FETCH) && mem_req && mem_ack && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  always_comb begin
    count_next = count;
    if (redirect)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      count <= count_next;
      if (push) begin
        buf_instr[wr_ptr] <= mem_rdata;
        buf_pc[wr_ptr]    <= mem_addr;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end

      // mem_addr tracks pc while requesting; it only diverges during FLUSH,
      // where it must keep the abandoned address until that request is acked.
      unique case (state)
        FETCH: begin
          if (redirect) begin
            pc <= target;
            if (mem_req && !mem_ack) begin
              state <= FLUSH;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= target;
            end
          end else if (!(mem_req && !mem_ack)) begin
            if (mem_req) begin
              pc       <= pc_inc;
              mem_addr <= pc_inc;
            end else begin
              mem_addr <= pc;
            end
            mem_req <= (count_next < DEPTH_C);
          end
        end
        FLUSH: begin
          if (redirect)
            pc <= target;
          if (mem_ack) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= redirect ? target : pc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign out_instr  = buf_instr[rd_ptr];
  assign out_pc     = buf_pc[rd_ptr];
  assign out_opcode = out_instr[6:0];
  assign out_rd     = out_instr[11:7];
  assign out_funct3 = out_instr[14:12];
  assign out_rs1    = out_instr[19:15];
  assign out_rs2    = out_instr[24:20];
  assign out_funct7 = out_instr[31:25];

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic opcode_legal;

  always_comb begin
    opcode_legal = 1'b0;
    case (out_opcode)
      7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  assign out_illegal = out_valid && !opcode_legal;
`else
  assign out_illegal = 1'b0;
`endif

endmodule
